// File: rtl/proc_ctrl.sv
// Control FSM for a tiny four-step processor: decodes mv/mvi/add/sub
// and drives register strobes, ALU op and bus mux select.
module proc_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [DW-1:0] din,
  output logic          ir_en,
  output logic [7:0]    r_en,
  output logic          a_en,
  output logic          g_en,
  output logic          addsub,
  output logic [3:0]    sel,
  output logic          done,
  output logic          busy,
  output logic          illegal
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_ir;
  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_x_hot;
  logic       w_unused;

  assign w_op     = r_ir[8:6];
  assign w_x      = r_ir[5:3];
  assign w_y      = r_ir[2:0];
  assign w_x_hot  = 8'd1 << w_x;
  assign w_unused = ^din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == T0 && run)
        r_ir <= din[8:0];
    end
  end

  always_comb begin
    w_next = T0;
    unique case (r_state)
      T0:      w_next = run ? T1 : T0;
      T1:      w_next = (w_op[2:1] == 2'b01) ? T2 : T0;
      T2:      w_next = T3;
      T3:      w_next = T0;
      default: w_next = T0;
    endcase
  end

  always_comb begin
    ir_en   = 1'b0;
    r_en    = '0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    addsub  = 1'b0;
    sel     = 4'd0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (r_state != T0);
    unique case (r_state)
      T0: ir_en = run & ~rst;
      T1: begin
        unique case (1'b1)
          (w_op == 3'b000): begin
            sel  = {1'b0, w_y} + 4'd1;
            r_en = w_x_hot;
            done = 1'b1;
          end
          (w_op == 3'b001): begin
            sel  = 4'd9;
            r_en = w_x_hot;
            done = 1'b1;
          end
          (w_op[2:1] == 2'b01): begin
            sel  = {1'b0, w_x} + 4'd1;
            a_en = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      T2: begin
        sel    = {1'b0, w_y} + 4'd1;
        g_en   = 1'b1;
        addsub = w_op[0];
      end
      T3: begin
        r_en = w_x_hot;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: walks each opcode, reset abort
// and back-to-back issue, checking all outputs every step.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] din;
  logic        ir_en;
  logic [7:0]  r_en;
  logic        a_en;
  logic        g_en;
  logic        addsub;
  logic [3:0]  sel;
  logic        done;
  logic        busy;
  logic        illegal;

  int n_run  = 0;
  int n_fail = 0;

  proc_ctrl #(.DW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .ir_en(ir_en), .r_en(r_en), .a_en(a_en), .g_en(g_en),
    .addsub(addsub), .sel(sel), .done(done),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {ir_en, r_en, a_en, g_en, addsub,
                sel, done, busy, illegal};

  function automatic logic [18:0] pk(
    input logic       ir,
    input logic [7:0] re,
    input logic       a,
    input logic       g,
    input logic       as,
    input logic [3:0] s,
    input logic       d,
    input logic       b,
    input logic       il
  );
    return {ir, re, a, g, as, s, d, b, il};
  endfunction

  task automatic cyc(input logic r, input logic rn,
                     input logic [15:0] d);
    @(negedge clk);
    rst = r;
    run = rn;
    din = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    din = '0;
    cyc(1, 1, 16'h0000);
    cyc(1, 1, 16'h0041);
    chk("reset_held", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("idle", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));

    cyc(0, 1, 16'h001D);
    chk("mv_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'hFFFF);
    chk("mv_t1", pk(0, 8'h08, 0, 0, 0, 4'd6, 1, 1, 0));
    cyc(0, 0, 16'h0000);
    chk("mv_after", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));

    cyc(0, 1, 16'h0040);
    chk("mvi_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h1234);
    chk("mvi_t1", pk(0, 8'h01, 0, 0, 0, 4'd9, 1, 1, 0));

    cyc(0, 1, 16'h00D7);
    chk("sub_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 1, 16'hFFFF);
    chk("sub_t1", pk(0, 8'h00, 1, 0, 0, 4'd3, 0, 1, 0));
    cyc(0, 1, 16'h0000);
    chk("sub_t2", pk(0, 8'h00, 0, 1, 1, 4'd8, 0, 1, 0));
    cyc(0, 0, 16'h0000);
    chk("sub_t3", pk(0, 8'h04, 0, 0, 0, 4'd0, 1, 1, 0));

    cyc(0, 1, 16'h01AA);
    chk("ill_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("ill_t1", pk(0, 8'h00, 0, 0, 0, 4'd0, 1, 1, 1));

    cyc(0, 1, 16'h008A);
    chk("add_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("add_t1", pk(0, 8'h00, 1, 0, 0, 4'd2, 0, 1, 0));
    cyc(1, 0, 16'h0000);
    chk("add_t2_rst", pk(0, 8'h00, 0, 1, 0, 4'd3, 0, 1, 0));
    cyc(0, 0, 16'h0000);
    chk("abort_1", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("abort_2", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 1, 16'h0001);
    chk("post_t0", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("post_t1", pk(0, 8'h01, 0, 0, 0, 4'd2, 1, 1, 0));

    cyc(0, 1, 16'h0038);
    chk("b2b_c1", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 1, 16'h0000);
    chk("b2b_c2", pk(0, 8'h80, 0, 0, 0, 4'd1, 1, 1, 0));
    cyc(0, 1, 16'h00A6);
    chk("b2b_c3", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 1, 16'h0000);
    chk("b2b_c4", pk(0, 8'h00, 1, 0, 0, 4'd5, 0, 1, 0));
    cyc(0, 1, 16'h0000);
    chk("b2b_c5", pk(0, 8'h00, 0, 1, 0, 4'd7, 0, 1, 0));
    cyc(0, 1, 16'h0000);
    chk("b2b_c6", pk(0, 8'h10, 0, 0, 0, 4'd0, 1, 1, 0));
    cyc(0, 1, 16'h000A);
    chk("b2b_c7", pk(1, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));
    cyc(0, 0, 16'h0000);
    chk("b2b_c8", pk(0, 8'h02, 0, 0, 0, 4'd3, 1, 1, 0));
    cyc(0, 0, 16'h0000);
    chk("b2b_idle", pk(0, 8'h00, 0, 0, 0, 4'd0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
